// File: rtl/sync_fifo_param.sv
// Purpose : parametrised single-clock FIFO with water level, flush and sticky error flags.
// Latency : standard mode rd_data/rd_valid one cycle after an accepted read; with
//           SYNC_FIFO_FWFT_EN the head word is shown two edges after its write.
// Backpressure: writes are dropped while wr_full, reads while rd_empty (both raise sticky errors).
// Ports   : clk, rst_n (async active-low), clr (sync flush);
//           wr_en/wr_data/wr_full/almost_full; rd_en/rd_data/rd_valid/rd_empty/almost_empty;
//           water_level (0..DEPTH), overflow, underflow.
// Option  : define SYNC_FIFO_FWFT_EN for first-word-fall-through mode.
module sync_fifo_param #(
    parameter int DATA_WIDTH       = 24,
    parameter int ADDR_WIDTH       = 11,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   water_level,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   LVL_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0]   AF_LVL   = ALMOST_FULL_NUM[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   AE_LVL   = ALMOST_EMPTY_NUM[ADDR_WIDTH:0];

    if (ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH) begin : g_bad_af
        $error("sync_fifo_param: ALMOST_FULL_NUM out of range 1..DEPTH");
    end
    if (ALMOST_EMPTY_NUM < 0 || ALMOST_EMPTY_NUM > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_param: ALMOST_EMPTY_NUM out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   level_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_rd;

    // clr wins over both requests, so neither is accepted in a flush cycle.
    assign wr_acc = wr_en & ~wr_full & ~clr;
    assign rd_acc = rd_en & ~rd_empty & ~clr;

    always_comb begin
        level_nxt = water_level;
        if (wr_acc && !rd_acc) begin
            level_nxt = water_level + LVL_ONE;
        end else if (!wr_acc && rd_acc) begin
            level_nxt = water_level - LVL_ONE;
        end
    end

    // Write and read addresses can only coincide at level 0 (no read) or
    // DEPTH (no write), so no read-during-write handling is needed.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            water_level  <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (clr) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            water_level  <= '0;
            wr_full      <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            water_level  <= level_nxt;
            wr_full      <= (level_nxt == FULL_LVL);
            almost_full  <= (level_nxt >= AF_LVL);
            almost_empty <= (level_nxt <= AE_LVL);
            if (wr_en && wr_full) begin
                overflow <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Two-stage head: ram_q is the RAM's registered read, rd_data the prefetch
    // register. Both refill on the acknowledging edge, so streaming has no bubble.
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  ram_q_vld;
    logic                  pf_load;
    logic                  ram_empty;

    // Words still in the array = level minus the ones parked in ram_q / rd_data.
    assign ram_empty = (water_level == {{(ADDR_WIDTH-1){1'b0}},
                                        ram_q_vld & ~rd_empty,
                                        ram_q_vld ^ ~rd_empty});
    assign pf_load   = ram_q_vld & (rd_empty | rd_acc);
    assign ram_rd    = ~clr & ~ram_empty & (~ram_q_vld | pf_load);
    assign rd_valid  = ~rd_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_q     <= '0;
            ram_q_vld <= 1'b0;
            rd_data   <= '0;
            rd_empty  <= 1'b1;
        end else if (clr) begin
            ram_q_vld <= 1'b0;
            rd_empty  <= 1'b1;
        end else begin
            if (ram_rd) begin
                ram_q     <= mem[rd_ptr];
                ram_q_vld <= 1'b1;
            end else if (pf_load) begin
                ram_q_vld <= 1'b0;
            end
            if (pf_load) begin
                rd_data  <= ram_q;
                rd_empty <= 1'b0;
            end else if (rd_acc) begin
                rd_empty <= 1'b1;
            end
        end
    end
`else
    assign ram_rd = rd_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_empty <= 1'b1;
        end else if (clr) begin
            rd_valid <= 1'b0;
            rd_empty <= 1'b1;
        end else begin
            rd_valid <= rd_acc;
            rd_empty <= (level_nxt == '0);
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Purpose : directed self-checking bench for sync_fifo_param (DEPTH 16, AF 14, AE 2).
// Latency : outputs are sampled 1 ns after each rising edge.
// Backpressure: exercised through full/empty drops and the sticky error flags.
module tb_sync_fifo_param;
    localparam int DW = 24;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic          almost_full;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_empty;
    logic          almost_empty;
    logic [AW:0]   water_level;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_NUM(14), .ALMOST_EMPTY_NUM(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full), .almost_full(almost_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
        .almost_empty(almost_empty), .water_level(water_level),
        .overflow(overflow), .underflow(underflow)
    );

    typedef struct packed {
        logic        clr;
        logic        wr;
        logic        rd;
        logic [23:0] wd;
        logic [4:0]  lvl;
        logic        full;
        logic        af;
        logic        emp;
        logic        ae;
        logic        ov;
        logic        un;
        logic        rv;
        logic [23:0] rdat;
    } vec_t;

    vec_t tv [35];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    endtask

    task automatic check_all(input string tag, input int idx, input logic [4:0] lvl,
                             input logic full, input logic af, input logic emp,
                             input logic ae, input logic ov, input logic un,
                             input logic rv, input logic [23:0] rdat);
        chk({tag, ".level"},        idx, 32'(water_level),  32'(lvl));
        chk({tag, ".wr_full"},      idx, 32'(wr_full),      32'(full));
        chk({tag, ".almost_full"},  idx, 32'(almost_full),  32'(af));
        chk({tag, ".rd_empty"},     idx, 32'(rd_empty),     32'(emp));
        chk({tag, ".almost_empty"}, idx, 32'(almost_empty), 32'(ae));
        chk({tag, ".overflow"},     idx, 32'(overflow),     32'(ov));
        chk({tag, ".underflow"},    idx, 32'(underflow),    32'(un));
        chk({tag, ".rd_valid"},     idx, 32'(rd_valid),     32'(rv));
        chk({tag, ".rd_data"},      idx, 32'(rd_data),      32'(rdat));
    endtask

    // Drive one cycle of inputs and sample 1 ns after the edge.
    task automatic cyc(input logic c, input logic w, input logic r, input logic [23:0] d);
        clr = c; wr_en = w; rd_en = r; wr_data = d;
        @(posedge clk);
        #1;
        clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        #12;
        check_all("reset", 0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 24'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef SYNC_FIFO_FWFT_EN
        // Fill to full, one overflowing write, drain, one underflowing read, flush.
        for (int i = 0; i < 16; i++)
            tv[i] = '{clr: 1'b0, wr: 1'b1, rd: 1'b0, wd: 24'(i + 1), lvl: 5'(i + 1),
                      full: (i == 15), af: (i >= 13), emp: 1'b0, ae: (i <= 1),
                      ov: 1'b0, un: 1'b0, rv: 1'b0, rdat: 24'h0};
        tv[16] = '{clr: 1'b0, wr: 1'b1, rd: 1'b0, wd: 24'h11, lvl: 5'd16, full: 1'b1,
                   af: 1'b1, emp: 1'b0, ae: 1'b0, ov: 1'b1, un: 1'b0, rv: 1'b0, rdat: 24'h0};
        for (int j = 0; j < 16; j++)
            tv[17 + j] = '{clr: 1'b0, wr: 1'b0, rd: 1'b1, wd: 24'h0, lvl: 5'(15 - j),
                           full: 1'b0, af: (j <= 1), emp: (j == 15), ae: (j >= 13),
                           ov: 1'b1, un: 1'b0, rv: 1'b1, rdat: 24'(j + 1)};
        tv[33] = '{clr: 1'b0, wr: 1'b0, rd: 1'b1, wd: 24'h0, lvl: 5'd0, full: 1'b0,
                   af: 1'b0, emp: 1'b1, ae: 1'b1, ov: 1'b1, un: 1'b1, rv: 1'b0, rdat: 24'h10};
        tv[34] = '{clr: 1'b1, wr: 1'b1, rd: 1'b1, wd: 24'h77, lvl: 5'd0, full: 1'b0,
                   af: 1'b0, emp: 1'b1, ae: 1'b1, ov: 1'b0, un: 1'b0, rv: 1'b0, rdat: 24'h10};

        for (int k = 0; k < 35; k++) begin
            cyc(tv[k].clr, tv[k].wr, tv[k].rd, tv[k].wd);
            check_all("vec", k, tv[k].lvl, tv[k].full, tv[k].af, tv[k].emp, tv[k].ae,
                      tv[k].ov, tv[k].un, tv[k].rv, tv[k].rdat);
        end

        // Full FIFO, read+write together: read taken, write dropped.
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 24'(32'h100 + i));
        cyc(0, 1, 1, 24'h999);
        check_all("full_rw", 0, 5'd15, 0, 1, 0, 0, 1, 0, 1, 24'h100);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 24'h0);
        check_all("drain8", 0, 5'd8, 0, 0, 0, 0, 1, 0, 1, 24'h107);
        cyc(0, 1, 1, 24'h200);
        check_all("mid_rw", 0, 5'd8, 0, 0, 0, 0, 1, 0, 1, 24'h108);

        // Streaming at level 3 across two pointer wraps.
        cyc(1, 0, 0, 24'h0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 24'(32'h300 + i));
        chk("stream.start_level", 0, 32'(water_level), 32'd3);
        for (int i = 0; i < 40; i++) begin
            cyc(0, 1, 1, 24'(32'h400 + i));
            chk("stream.level", i, 32'(water_level), 32'd3);
            chk("stream.rd_data", i, 32'(rd_data),
                (i < 3) ? 32'h300 + 32'(i) : 32'h400 + 32'(i - 3));
            chk("stream.rd_valid", i, 32'(rd_valid), 32'd1);
        end

        // Flush at level 9 with overflow set; the concurrent write is discarded.
        cyc(1, 0, 0, 24'h0);
        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 24'(32'h500 + i));
        cyc(0, 1, 0, 24'h5FF);
        for (int i = 0; i < 7; i++) cyc(0, 0, 1, 24'h0);
        check_all("pre_clr", 0, 5'd9, 0, 0, 0, 0, 1, 0, 1, 24'h506);
        cyc(1, 1, 0, 24'h555);
        check_all("clr", 0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 24'h506);
        cyc(0, 0, 0, 24'h0);
        check_all("post_clr", 0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 24'h506);
`else
        // Word written at edge k appears after edge k+2.
        cyc(0, 1, 0, 24'hABCDEF);
        chk("fwft.empty_k", 0, 32'(rd_empty), 32'd1);
        cyc(0, 0, 0, 24'h0);
        chk("fwft.empty_k1", 0, 32'(rd_empty), 32'd1);
        cyc(0, 0, 0, 24'h0);
        check_all("fwft.show", 0, 5'd1, 0, 0, 0, 1, 0, 0, 1, 24'hABCDEF);
        cyc(0, 0, 1, 24'h0);
        check_all("fwft.ack", 0, 5'd0, 0, 0, 1, 1, 0, 0, 0, 24'hABCDEF);

        // Back-to-back acknowledges show consecutive words without a bubble.
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 24'(32'h700 + i));
        cyc(0, 0, 0, 24'h0);
        cyc(0, 0, 0, 24'h0);
        for (int i = 0; i < 3; i++) begin
            chk("fwft.burst.data", i, 32'(rd_data), 32'h700 + 32'(i));
            chk("fwft.burst.empty", i, 32'(rd_empty), 32'd0);
            chk("fwft.burst.level", i, 32'(water_level), 32'(3 - i));
            cyc(0, 0, 1, 24'h0);
        end
        chk("fwft.burst.end", 0, 32'(rd_empty), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock FIFO, the successor to the fixed 2048x24 filter-line FIFO. Width, depth and almost-full/almost-empty thresholds are parameters. It adds a water-level output, a synchronous flush, and sticky overflow/underflow error flags. Used for pixel line buffering and stream decoupling inside the image filter pipeline.

Parameters:
- DATA_WIDTH, 24, word width in bits (1..1152).
- ADDR_WIDTH, 11, log2 of depth; DEPTH = 2^ADDR_WIDTH (4..20).
- ALMOST_FULL_NUM, 1020, almost_full asserts when level >= this; legal 1..DEPTH.
- ALMOST_EMPTY_NUM, 4, almost_empty asserts when level <= this; legal 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush, active-high.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- wr_full  out  1  FIFO full.
- almost_full  out  1  level >= ALMOST_FULL_NUM.
- rd_en  in  1  read request (acknowledge in FWFT mode).
- rd_data  out  DATA_WIDTH  read word.
- rd_valid  out  1  rd_data holds a newly read word.
- rd_empty  out  1  no word available to read.
- almost_empty  out  1  level <= ALMOST_EMPTY_NUM.
- water_level  out  ADDR_WIDTH+1  words held, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst_n low, asynchronous): wr_full=0, almost_full=0, rd_empty=1, almost_empty=1, water_level=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Pointers are zeroed. Memory contents are undefined.
- Write acceptance: wr_acc = wr_en & ~wr_full. wr_full is the registered flag. A write while full is dropped even if a read is accepted in the same cycle.
- Read acceptance: rd_acc = rd_en & ~rd_empty. A read while empty is dropped even if a write is accepted in the same cycle.
- Level update: water_level' = water_level + wr_acc - rd_acc.
  - Simultaneous accepted read and write leave the level unchanged.
  - Pointers wrap modulo DEPTH.
- Flags are registered and reflect the post-update level in the same cycle water_level updates:
  - wr_full = (level == DEPTH)
  - almost_full = (level >= ALMOST_FULL_NUM)
  - almost_empty = (level <= ALMOST_EMPTY_NUM)
- Standard mode (macro absent):
  - rd_empty = (level == 0).
  - Read latency is 1: rd_data updates and rd_valid pulses high for one cycle after the edge that accepted the read.
  - rd_data holds its last value otherwise.
- Error flags:
  - overflow sets on wr_en & wr_full.
  - underflow sets on rd_en & rd_empty.
  - Both stay set until clr or reset.
- clr:
  - Takes effect at the next edge: pointers and level go to 0, all flags go to their reset values, rd_valid=0.
  - rd_data holds its value.
  - clr has priority over wr_en and rd_en in the same cycle; both requests are dropped and do not set overflow or underflow.
- Memory: simple dual-port array, one write and one read per cycle. Inferable as block RAM with a registered read.
- Parameter checks: an illegal threshold triggers a $error during elaboration.

Optional Feature:
Macro SYNC_FIFO_FWFT_EN enables first-word-fall-through mode.
- With the macro:
  - A one-word prefetch register feeds rd_data.
  - rd_empty = prefetch register empty; rd_valid = ~rd_empty.
  - rd_en acknowledges the word currently shown; the next word appears after the acknowledging edge with no bubble while RAM holds data.
  - A word written into an empty FIFO at edge k shows on rd_data with rd_empty=0 after edge k+2.
  - water_level counts the prefetch register.
  - clr also empties the prefetch register.
- Without the macro: standard mode as specified above; no prefetch register is present.

Test Plan:
All scenarios use DATA_WIDTH=24, ADDR_WIDTH=4, ALMOST_FULL_NUM=14, ALMOST_EMPTY_NUM=2.
- Reset, then write 0x000001..0x000010 (16 words) -> almost_full rises after the 14th write, wr_full after the 16th, water_level=16. A 17th write sets overflow=1 and the level stays 16.
- Read 16 words in standard mode -> rd_data = 0x000001..0x000010 in order, each one cycle after its rd_en. almost_empty rises at level 2, rd_empty at level 0. A further rd_en sets underflow=1.
- FIFO at level 16, assert wr_en and rd_en together -> read accepted, write dropped, level=15, overflow=1. At level 8, assert both -> level stays 8.
- 40 streaming cycles with wr_en=rd_en=1 from level 3 -> pointers wrap twice, data order preserved, level constant at 3.
- Level 9 with overflow=1, pulse clr together with wr_en -> next cycle level=0, rd_empty=1, overflow=0, and the write is discarded.
- FWFT build: write 0xABCDEF at edge k into an empty FIFO -> rd_empty=0 and rd_data=0xABCDEF after edge k+2. rd_en for one cycle -> rd_empty=1 and level=0.
